// File: rtl/alu_cmd_queue_pkg.sv
// Shared ALU opcode encodings, command bundle and opcode legality helper
// for the ALU command queue and its ALU.
package alu_cmd_queue_pkg;

    localparam int ALUOP_W = 3;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD = 3'b000;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB = 3'b001;
    localparam logic [ALUOP_W-1:0] ALUOP_AND = 3'b010;
    localparam logic [ALUOP_W-1:0] ALUOP_OR  = 3'b011;
    localparam logic [ALUOP_W-1:0] ALUOP_SRL = 3'b100;
    localparam logic [ALUOP_W-1:0] ALUOP_SRA = 3'b101;

    typedef struct packed {
        logic [31:0]        a;
        logic [31:0]        b;
        logic [ALUOP_W-1:0] op;
    } cmd_t;

    function automatic logic is_legal_op(input logic [ALUOP_W-1:0] op);
        return op <= ALUOP_SRA;
    endfunction

endpackage

// File: rtl/alu_cmd_queue_alu.sv
// 32-bit combinational ALU: add/sub/and/or/srl/sra.
// Shifts take the full 32-bit B; amounts >= 32 saturate.
module alu
    import alu_cmd_queue_pkg::*;
(
    input  logic [31:0]        a,
    input  logic [31:0]        b,
    input  logic [ALUOP_W-1:0] op,
    output logic [31:0]        c
);

    logic big_shamt;

    assign big_shamt = |b[31:5];

    always_comb begin
        c = '0;
        case (op)
            ALUOP_ADD: c = a + b;
            ALUOP_SUB: c = a - b;
            ALUOP_AND: c = a & b;
            ALUOP_OR:  c = a | b;
            ALUOP_SRL: c = big_shamt ? '0 : (a >> b[4:0]);
            ALUOP_SRA: c = big_shamt ? {32{a[31]}}
                                     : 32'($signed(a) >>> b[4:0]);
            default:   c = '0;
        endcase
    end

endmodule

// File: rtl/alu_cmd_queue.sv
// Issue-stage command FIFO in front of the ALU with a one-entry
// registered result stage; valid/ready on both sides.
module alu_cmd_queue
    import alu_cmd_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_a,
    input  logic [W-1:0]             in_b,
    input  logic [2:0]               in_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_c,
    output logic                     out_err,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    cmd_t          mem_q [DEPTH];
    cmd_t          mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_c_q, out_c_d;
    logic          out_err_q, out_err_d;

    logic          push;
    logic          pop;
    cmd_t          head;
    logic [31:0]   alu_c;

    assign head = mem_q[rd_ptr_q];

    alu u_alu (
        .a  (head.a),
        .b  (head.b),
        .op (head.op),
        .c  (alu_c)
    );

    // Ready depends only on registered occupancy, never on a same-cycle pop.
    assign in_ready = !reset && !flush && (count_q < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (count_q != '0) && (!out_valid_q || out_ready) && !flush;

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_c_d     = out_c_q;
        out_err_d   = out_err_q;

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{a: in_a, b: in_b, op: in_op};
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d    = rd_ptr_q + 1'b1;
                out_valid_d = 1'b1;
                out_err_d   = !is_legal_op(head.op);
                out_c_d     = is_legal_op(head.op) ? W'(alu_c) : '0;
            end else if (out_ready && out_valid_q) begin
                out_valid_d = 1'b0;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_c_q     <= '0;
            out_err_q   <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_c_q     <= out_c_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_c     = out_c_q;
    assign out_err   = out_err_q;
    assign count     = count_q;

endmodule
